systolic_output_collector: RTL and testbench
============================================

// Module: systolic_output_collector
// PURPOSE
//  Receive end of the systolic MAC array. The array emits one 8-bit result per
//  column with a staircase skew: column k is valid k cycles after column 0.
//  This block de-skews the columns into one aligned row word and buffers the
//  rows in a FIFO. A downstream consumer (pooling or writeback) drains the FIFO
//  through a valid/ready handshake.
// PARAMETERS
//  DATA_SIZE   8   bits per column result (signed two's complement)
//  ARRAY_SIZE  9   number of array columns (N)
//  DEPTH       8   FIFO depth in rows; power of two, >= 2
// PORTS
//  s_clk       in   1                     single clock for the block
//  reset       in   1                     asynchronous reset, active-high
//  clear       in   1                     synchronous flush, active-high
//  mac_in      in   DATA_SIZE*ARRAY_SIZE  column results; lane k = bits [8k+7:8k]
//  col_valid   in   ARRAY_SIZE            per-column valid, skewed like r_en
//  out_data    out  DATA_SIZE*ARRAY_SIZE  aligned row at the FIFO head
//  out_valid   out  1                     FIFO not empty
//  out_ready   in   1                     consumer accepts out_data this cycle
//  fill_level  out  $clog2(DEPTH+1)       rows currently stored
//  overflow    out  1                     sticky: a row was dropped because the FIFO was full
//  skew_err    out  1                     sticky: aligned valids disagreed
// BEHAVIOUR
//  - Reset: asynchronous, active-high. All outputs, pointers, deskew registers
//    and sticky flags go to 0. out_valid=0.
//  - Deskew:
//    - Lane k passes through a chain of (N-1-k) registers, applied to both data
//      and valid. Lane N-1 has no delay.
//    - Aligned row: al_valid = AND of all delayed valids.
//    - If any delayed valid is 1 but not all are: set skew_err and drop the row.
//  - Push: al_valid=1 and the FIFO is not full. The row is written at the end
//    of that cycle.
//  - Latency: col_valid[0] at cycle t (lane k at t+k) -> out_valid=1 at t+N,
//    with out_data holding that row.
//  - Pop: out_valid & out_ready. The head advances at the clock edge.
//  - FIFO is show-ahead: out_data = mem[rd_ptr].
//    - Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
//    - fill_level counts 0..DEPTH.
//  - FIFO occupancy states: EMPTY (fill=0), PARTIAL, FULL (fill=DEPTH).
//    - EMPTY: a push moves to PARTIAL. out_ready is ignored.
//    - FULL with push and no pop: the row is dropped, overflow is set, and the
//      state stays FULL.
//    - FULL with push and pop together: both happen and fill stays DEPTH.
//    - PARTIAL with push and pop together: fill is unchanged.
//  - clear takes priority over push and pop. It empties the FIFO, zeroes the
//    deskew chains and clears overflow and skew_err on the next edge.
//    Rows still in flight are discarded.
//  - Reset asserted mid-stream: state is cleared immediately. No partial row
//    appears after reset is released.
//  - out_data is only meaningful while out_valid=1. It holds stable until popped.
// CONFIGURATION
//  - Macro COLLECTOR_RELU_EN.
//    - Defined: each lane is clamped to 0 when its MSB is 1, before the FIFO
//      write. Raw macout can then be connected directly.
//    - Undefined: lanes are stored unmodified. The input is already relu_out.
//  - Latency is identical in both builds.
// STRUCTURE
//  - Shared package cnn_pkg:
//    - DATA_SIZE and ARRAY_SIZE constants
//    - lane_t (DATA_SIZE-bit signed)
//    - row_t (ARRAY_SIZE lanes)
//  - Sub-module collector_fifo: synchronous show-ahead FIFO (row_t x DEPTH)
//    with push, pop, clear, full, empty and level.
//  - The deskew chains and flag logic are written inline in the top.
// TESTING (N=9, DEPTH=4)
//  1. Staircase col_valid (bit k rises at t+k) carrying rows 0x01..0x09
//     -> out_valid rises at t+9 and out_data lanes equal 0x01..0x09.
//  2. Five back-to-back rows with out_ready=0
//     -> fill_level=4, overflow=1, fifth row lost.
//     Then out_ready=1 -> rows 1..4 pop in order, then out_valid=0.
//  3. FULL plus simultaneous push and pop (out_ready=1)
//     -> fill stays 4, no overflow, output order preserved.
//  4. col_valid[3] held low for one row
//     -> skew_err=1 and that row is not stored; the next good row is stored.
//  5. With COLLECTOR_RELU_EN: lane value 0x85 -> stored as 0x00, 0x7F kept.
//     Without it -> 0x85 kept.
//  6. reset or clear pulsed with 2 rows stored and 1 row in flight
//     -> fill_level=0, out_valid=0, flags 0, no stale row afterwards.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types for the CNN datapath: lane and row words of the MAC array.
package cnn_pkg;

  localparam int DATA_SIZE  = 8;
  localparam int ARRAY_SIZE = 9;

  typedef logic signed [DATA_SIZE-1:0] lane_t;
  typedef lane_t [ARRAY_SIZE-1:0]      row_t;

  function automatic lane_t relu(lane_t v);
    return v[DATA_SIZE-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/collector_fifo.sv
// Show-ahead row FIFO; a push into a full FIFO is accepted only alongside a pop.
module collector_fifo
  import cnn_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  row_t          wdata,
  output row_t          rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  row_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push & ~clr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/systolic_output_collector.sv
// De-skews staircase column results into aligned rows and queues them.
// Build option: COLLECTOR_RELU_EN clamps negative lanes to zero before storage.
module systolic_output_collector
  import cnn_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                           s_clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic [DATA_SIZE*ARRAY_SIZE-1:0] mac_in,
  input  logic [ARRAY_SIZE-1:0]           col_valid,
  output logic [DATA_SIZE*ARRAY_SIZE-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LW-1:0]                  fill_level,
  output logic                           overflow,
  output logic                           skew_err
);

  localparam int N = ARRAY_SIZE;

  row_t            mac_row;
  row_t            dly_row;
  logic [N-1:0]    dly_vld;
  row_t            wr_row;
  row_t            rd_row;
  logic            al_valid;
  logic            skew_hit;
  logic            full;
  logic            empty;
  logic            pop;

  assign mac_row = mac_in;

  // Lane k waits N-1-k cycles so all lanes of one row meet together.
  for (genvar k = 0; k < N; k++) begin : g_lane
    localparam int D = N - 1 - k;
    if (D == 0) begin : g_pass
      assign dly_row[k] = mac_row[k];
      assign dly_vld[k] = col_valid[k];
    end else begin : g_chain
      lane_t        d_q [D];
      logic [D-1:0] v_q;
      always_ff @(posedge s_clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < D; i++) d_q[i] <= '0;
          v_q <= '0;
        end else if (clear) begin
          for (int i = 0; i < D; i++) d_q[i] <= '0;
          v_q <= '0;
        end else begin
          d_q[0] <= mac_row[k];
          v_q[0] <= col_valid[k];
          for (int i = 1; i < D; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end
      assign dly_row[k] = d_q[D-1];
      assign dly_vld[k] = v_q[D-1];
    end
  end

  assign al_valid = &dly_vld;
  assign skew_hit = (|dly_vld) & ~al_valid;

  always_comb begin
    wr_row = dly_row;
`ifdef COLLECTOR_RELU_EN
    for (int k = 0; k < N; k++) wr_row[k] = relu(dly_row[k]);
`endif
  end

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign out_data  = rd_row;

  collector_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (s_clk),
    .rst   (reset),
    .clr   (clear),
    .push  (al_valid),
    .pop   (pop),
    .wdata (wr_row),
    .rdata (rd_row),
    .full  (full),
    .empty (empty),
    .level (fill_level)
  );

  always_ff @(posedge s_clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      if (skew_hit)                  skew_err <= 1'b1;
      if (al_valid & full & ~pop)    overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_systolic_output_collector.sv
// Directed + random bench for systolic_output_collector against a row-queue model.
module tb_systolic_output_collector;
  import cnn_pkg::*;

  localparam int N     = ARRAY_SIZE;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int MAXC  = 1024;

  logic                           s_clk = 1'b0;
  logic                           reset;
  logic                           clear;
  logic [DATA_SIZE*ARRAY_SIZE-1:0] mac_in;
  logic [ARRAY_SIZE-1:0]           col_valid;
  logic [DATA_SIZE*ARRAY_SIZE-1:0] out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [LW-1:0]                  fill_level;
  logic                           overflow;
  logic                           skew_err;

  systolic_output_collector #(.DEPTH(DEPTH)) dut (
    .s_clk      (s_clk),
    .reset      (reset),
    .clear      (clear),
    .mac_in     (mac_in),
    .col_valid  (col_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_level (fill_level),
    .overflow   (overflow),
    .skew_err   (skew_err)
  );

  always #5 s_clk = ~s_clk;

  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  row_t         iss_row  [MAXC];
  logic [N-1:0] iss_mask [MAXC];
  row_t         q [$];
  bit           m_ovf;
  bit           m_skw;
  localparam logic [N-1:0] ALL = '1;

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic row_t model_relu(row_t r);
    row_t o = r;
`ifdef COLLECTOR_RELU_EN
    for (int k = 0; k < N; k++) if (r[k][DATA_SIZE-1]) o[k] = '0;
`endif
    return o;
  endfunction

  function automatic row_t rnd_row();
    row_t r;
    for (int k = 0; k < N; k++) r[k] = lane_t'($urandom_range(0, 255));
    return r;
  endfunction

  task automatic wipe();
    for (int i = 0; i < MAXC; i++) iss_mask[i] = '0;
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf = 0;
    m_skw = 0;
    wipe();
  endtask

  task automatic drive();
    row_t r;
    for (int k = 0; k < N; k++) begin
      int idx = cyc - k;
      if (idx >= 0 && iss_mask[idx][k]) begin
        col_valid[k] = 1'b1;
        r[k] = iss_row[idx][k];
      end else begin
        col_valid[k] = 1'b0;
        r[k] = lane_t'($urandom_range(0, 255));
      end
    end
    mac_in = r;
  endtask

  // A row issued at cycle a lands at the FIFO at the end of cycle a+N-1.
  task automatic model_edge();
    int a;
    logic [N-1:0] m;
    bit was_full;
    bit do_pop;
    if (clear) begin
      model_clear();
      return;
    end
    a = cyc - (N - 1);
    m = (a >= 0) ? iss_mask[a] : '0;
    was_full = (q.size() == DEPTH);
    do_pop = (q.size() != 0) && out_ready;
    if (do_pop) void'(q.pop_front());
    if (m == ALL) begin
      if (!was_full || do_pop) q.push_back(model_relu(iss_row[a]));
      else m_ovf = 1;
    end else if (m != '0) begin
      m_skw = 1;
    end
  endtask

  task automatic check_all();
    chk("out_valid", 72'(out_valid), 72'(q.size() != 0));
    chk("fill_level", 72'(fill_level), 72'(q.size()));
    chk("overflow", 72'(overflow), 72'(m_ovf));
    chk("skew_err", 72'(skew_err), 72'(m_skw));
    if (q.size() != 0) chk("out_data", out_data, q[0]);
  endtask

  task automatic cycle(input bit iss, input row_t r, input logic [N-1:0] m);
    if (iss && cyc < MAXC) begin
      iss_row[cyc]  = r;
      iss_mask[cyc] = m;
    end
    drive();
    @(posedge s_clk);
    model_edge();
    cyc++;
    @(negedge s_clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0);
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    model_clear();
    col_valid = '0;
    #1;
    chk("rst_valid", 72'(out_valid), 72'(0));
    chk("rst_fill", 72'(fill_level), 72'(0));
    chk("rst_flags", 72'({overflow, skew_err}), 72'(0));
    @(posedge s_clk);
    cyc++;
    @(negedge s_clk);
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    row_t r;
    int   t0;
    int   lat;
    reset = 1'b1;
    clear = 1'b0;
    mac_in = '0;
    col_valid = '0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge s_clk);
    @(negedge s_clk);
    chk("reset_valid", 72'(out_valid), 72'(0));
    chk("reset_fill", 72'(fill_level), 72'(0));
    chk("reset_flags", 72'({overflow, skew_err}), 72'(0));
    chk("reset_data", out_data, 72'(0));
    reset = 1'b0;

    // 1: staircase row 0x01..0x09, latency N
    for (int k = 0; k < N; k++) r[k] = lane_t'(k + 1);
    t0 = cyc;
    lat = -1;
    cycle(1, r, ALL);
    for (int i = 0; i < 20 && lat < 0; i++) begin
      idle(1);
      if (out_valid === 1'b1) lat = cyc - t0;
    end
    chk("latency", 72'(lat), 72'(N));
    chk("row1_data", out_data, 72'h090807060504030201);

    // 2: five rows, no drain -> overflow, then ordered drain
    out_ready = 1'b1;
    idle(2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1, rnd_row(), ALL);
    idle(10);
    chk("ovf_fill", 72'(fill_level), 72'(DEPTH));
    chk("ovf_flag", 72'(overflow), 72'(1));
    out_ready = 1'b1;
    idle(6);
    chk("drained", 72'(out_valid), 72'(0));

    // 3: full with simultaneous push and pop
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (q.size() == DEPTH) out_ready = 1'b1;
      cycle(i < 12, rnd_row(), ALL);
    end
    chk("fullpp_ovf", 72'(overflow), 72'(0));
    idle(6);

    // 4: one lane missing -> skew_err, row dropped; next row kept
    out_ready = 1'b0;
    cycle(1, rnd_row(), ALL & ~(N'(1) << 3));
    cycle(1, rnd_row(), ALL);
    idle(12);
    chk("skew_flag", 72'(skew_err), 72'(1));
    chk("skew_fill", 72'(fill_level), 72'(1));

    // 5: negative lane handling
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    r = rnd_row();
    r[0] = 8'h85;
    r[1] = 8'h7F;
    cycle(1, r, ALL);
    idle(10);
`ifdef COLLECTOR_RELU_EN
    chk("relu_neg", 72'(out_data[7:0]), 72'(8'h00));
`else
    chk("relu_neg", 72'(out_data[7:0]), 72'(8'h85));
`endif
    chk("relu_pos", 72'(out_data[15:8]), 72'(8'h7F));

    // 6: clear, then reset, each with 2 rows stored and 1 in flight
    for (int pass = 0; pass < 2; pass++) begin
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      out_ready = 1'b0;
      cycle(1, rnd_row(), ALL);
      cycle(1, rnd_row(), ALL);
      idle(9);
      cycle(1, rnd_row(), ALL);
      cycle(1, rnd_row(), ALL & ~(N'(1) << 2));
      idle(3);
      if (pass == 0) begin
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
      end else begin
        mid_reset();
      end
      idle(14);
      chk("flush_fill", 72'(fill_level), 72'(0));
      chk("flush_flags", 72'({overflow, skew_err}), 72'(0));
    end

    // random traffic
    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] m;
      m = ($urandom_range(0, 7) == 0) ? N'($urandom) : ALL;
      out_ready = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 60) == 0);
      cycle($urandom_range(0, 1) == 1, rnd_row(), m);
      clear = 1'b0;
    end
    out_ready = 1'b1;
    idle(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
